// File: rtl/filter_pkg.sv
// Shared types and helpers for the FIR filter datapath and its feeder.
package filter_pkg;

  localparam int DATAWIDTH = 8;
  localparam int FIR_N     = 4;

  typedef logic signed [DATAWIDTH-1:0] sample_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; no bypass, pushes stall while full.
module sync_fifo
  import filter_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic [W-1:0]                data_i,
  input  logic                        pop_i,
  output logic [W-1:0]                data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [clog2(DEPTH+1)-1:0]   level_o
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/sample_feeder.sv
// Buffers bursty samples and releases one to the filter every DIV enabled clocks.
// SAMPLE_FEEDER_HOLD_EN: on underflow x_out holds its last value instead of zero.
module sample_feeder
  import filter_pkg::*;
#(
  parameter int datawidth = DATAWIDTH,
  parameter int DEPTH     = 16,
  parameter int DIV       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [datawidth-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [datawidth-1:0] x_out,
  output logic                        x_strobe,
  output logic                        underflow,
  output logic                        underflow_seen,
  output logic [clog2(DEPTH+1)-1:0]   level
);

  localparam int CW = (DIV > 1) ? clog2(DIV) : 1;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 tick;
  logic                 fifo_full, fifo_empty;
  logic [datawidth-1:0] fifo_dat;
  logic [datawidth-1:0] x_out_q, x_out_d;
  logic                 x_strobe_q, underflow_q, underflow_seen_q;

  sync_fifo #(
    .W     (datawidth),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .data_i  (in_data),
    .pop_i   (tick),
    .data_o  (fifo_dat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  assign in_ready = !fifo_full;

  always_comb begin
    tick    = en && (cnt_q == CW'(DIV-1));
    cnt_d   = cnt_q;
    x_out_d = x_out_q;
    if (en) cnt_d = tick ? '0 : cnt_q + CW'(1);
    if (tick) begin
      if (!fifo_empty) x_out_d = fifo_dat;
`ifdef SAMPLE_FEEDER_HOLD_EN
      else             x_out_d = x_out_q;
`else
      else             x_out_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q            <= '0;
      x_out_q          <= '0;
      x_strobe_q       <= 1'b0;
      underflow_q      <= 1'b0;
      underflow_seen_q <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      x_out_q          <= x_out_d;
      x_strobe_q       <= tick;
      underflow_q      <= tick && fifo_empty;
      underflow_seen_q <= underflow_seen_q || (tick && fifo_empty);
    end
  end

  assign x_out          = x_out_q;
  assign x_strobe       = x_strobe_q;
  assign underflow      = underflow_q;
  assign underflow_seen = underflow_seen_q;

endmodule
